pq_rr_sched: RTL and testbench

//  Round-robin scheduler that shares one two-phase register-array priority queue among NREQ

---
 rtl/pq_pkg.sv | 24 ++
 rtl/pq_rr_pick.sv | 44 ++++
 rtl/pq_rr_sched.sv | 154 +++++++++++++++
 tb/tb_pq_rr_sched.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pq_pkg.sv
// rtl/pq_pkg.sv - shared types and constants for the priority queue and its scheduler
// Purpose: key/value pair type, queue sizing, idle pair constant and scheduler state type.
// Ports: none (package).
package pq_pkg;

  localparam int KEY_W       = 8;
  localparam int VAL_W       = 8;
  localparam int PQ_CAPACITY = 8;
  localparam int PQ_CNT_W    = $clog2(PQ_CAPACITY + 1);

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } kv_t;

  localparam logic [KEY_W-1:0] KEYINF = '1;
  localparam logic [VAL_W-1:0] VAL0   = '0;

  // Pair driven on the queue input and held on the response bus when idle.
  localparam kv_t KV_IDLE = '{key: KEYINF, val: VAL0};

  typedef enum logic {SCH_RUN, SCH_FLUSH} sched_state_t;

endpackage

// File: rtl/pq_rr_pick.sv
// rtl/pq_rr_pick.sv - rotating-priority one-hot picker
// Purpose: grant the first eligible requester searching i_ptr, i_ptr+1, ... mod NREQ.
// Ports:
//   i_eligible  NREQ    requesters that may be granted this cycle
//   i_ptr       PTR_W   index with highest priority
//   o_gnt       NREQ    one-hot grant (zero when nothing is eligible)
//   o_idx       PTR_W   encoded index of the grant
//   o_any       1       a grant was made
module pq_rr_pick #(
  parameter int NREQ  = 4,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  i_eligible,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_gnt,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_any
);

  logic [31:0]      w_pos;
  logic [PTR_W-1:0] w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_pos = '0;
    w_j   = '0;
    for (int k = 0; k < NREQ; k++) begin
      // Wrap the search position without a modulo so NREQ need not be a power of two.
      w_pos = 32'(i_ptr) + 32'(k);
      if (w_pos >= 32'(NREQ)) begin
        w_pos = w_pos - 32'(NREQ);
      end
      w_j = PTR_W'(w_pos);
      if (!o_any && i_eligible[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/pq_rr_sched.sv
// rtl/pq_rr_sched.sv - round-robin scheduler sharing one two-phase priority queue
// Purpose: arbitrate enqueue/dequeue/replace requests from NREQ requesters onto one queue,
//   return dequeued pairs to their requester, track occupancy and drain on flush.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_enq/req_deq/req_kv   per-requester requests (enq & deq = replace) and insert pair
//   gnt                      one-hot grant in the issue cycle (combinational)
//   rsp_valid/rsp_kv         one-cycle response pulse and dequeued pair
//   flush/flushing/flush_done  drain command, drain-in-progress, drain-complete pulse
//   count                    queue occupancy
//   pq_enq/pq_deq/pq_kvi     queue command side
//   pq_kvo/pq_full/pq_empty/pq_busy  queue status side
module pq_rr_sched
  import pq_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_enq,
  input  logic [NREQ-1:0]     req_deq,
  input  kv_t  [NREQ-1:0]     req_kv,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     rsp_valid,
  output kv_t                 rsp_kv,
  input  logic                flush,
  output logic                flushing,
  output logic                flush_done,
  output logic [PQ_CNT_W-1:0] count,
  output logic                pq_enq,
  output logic                pq_deq,
  output kv_t                 pq_kvi,
  input  kv_t                 pq_kvo,
  input  logic                pq_full,
  input  logic                pq_empty,
  input  logic                pq_busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  sched_state_t        r_state;
  sched_state_t        w_state_nxt;
  logic [PTR_W-1:0]    r_ptr;
  logic [PQ_CNT_W-1:0] r_count;
  logic [NREQ-1:0]     r_rsp_valid;
  kv_t                 r_rsp_kv;

  logic [NREQ-1:0]     w_elig;
  logic [NREQ-1:0]     w_pick_gnt;
  logic [PTR_W-1:0]    w_idx;
  logic                w_pick_any;
  logic                w_issue;
  logic                w_arb;
  logic                w_grant;
  logic                w_grant_enq;
  logic                w_grant_deq;
  logic                w_flush_deq;

  // Enq-only needs room; deq and replace need a head to remove.
  for (genvar g = 0; g < NREQ; g++) begin : g_elig
    assign w_elig[g] = (req_enq[g] & ~req_deq[g] & ~pq_full) | (req_deq[g] & ~pq_empty);
  end

  pq_rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .i_eligible (w_elig),
    .i_ptr      (r_ptr),
    .o_gnt      (w_pick_gnt),
    .o_idx      (w_idx),
    .o_any      (w_pick_any)
  );

  // The queue only accepts a command in its idle phase; reset suppresses all commands.
  assign w_issue = ~rst & ~pq_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SCH_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arb       = 1'b0;
    w_flush_deq = 1'b0;
    flushing    = 1'b0;
    flush_done  = 1'b0;
    case (r_state)
      SCH_RUN: begin
        w_arb = w_issue;
        if (flush) begin
          w_state_nxt = SCH_FLUSH;
        end
      end
      SCH_FLUSH: begin
        flushing = 1'b1;
        if (w_issue) begin
          if (pq_empty) begin
            flush_done  = 1'b1;
            w_state_nxt = SCH_RUN;
          end else begin
            w_flush_deq = 1'b1;
          end
        end
      end
      default: w_state_nxt = SCH_RUN;
    endcase
  end

  assign w_grant     = w_arb & w_pick_any;
  assign w_grant_enq = w_grant & req_enq[w_idx];
  assign w_grant_deq = w_grant & req_deq[w_idx];

  assign gnt    = w_grant ? w_pick_gnt : '0;
  assign pq_enq = w_grant_enq;
  assign pq_deq = w_grant_deq | w_flush_deq;
  assign pq_kvi = w_grant ? req_kv[w_idx] : KV_IDLE;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_count     <= '0;
      r_rsp_valid <= '0;
      r_rsp_kv    <= KV_IDLE;
    end else begin
      if (w_grant) begin
        r_ptr <= (w_idx == PTR_W'(NREQ - 1)) ? '0 : w_idx + 1'b1;
      end
      // pq_kvo is the head before this cycle's removal, i.e. the pair being dequeued.
      r_rsp_valid <= w_grant_deq ? w_pick_gnt : '0;
      if (w_grant_deq) begin
        r_rsp_kv <= pq_kvo;
      end
      // Replace leaves occupancy unchanged; the guards keep count from wrapping.
      if (pq_enq && !pq_deq && r_count != PQ_CNT_W'(PQ_CAPACITY)) begin
        r_count <= r_count + 1'b1;
      end else if (pq_deq && !pq_enq && r_count != '0) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign count     = r_count;
  assign rsp_valid = r_rsp_valid;
  assign rsp_kv    = r_rsp_kv;

  a_count_full: assert property (@(posedge clk) disable iff (rst)
    (r_count == PQ_CNT_W'(PQ_CAPACITY)) == pq_full);

endmodule

// File: tb/tb_pq_rr_sched.sv
// tb/tb_pq_rr_sched.sv - self-checking bench for pq_rr_sched with a behavioural queue
module tb_pq_rr_sched;
  import pq_pkg::*;

  localparam int NREQ = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req_enq = '0;
  logic [NREQ-1:0]     req_deq = '0;
  kv_t  [NREQ-1:0]     req_kv = '0;
  logic                flush = 1'b0;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     rsp_valid;
  kv_t                 rsp_kv;
  logic                flushing;
  logic                flush_done;
  logic [PQ_CNT_W-1:0] count;
  logic                pq_enq;
  logic                pq_deq;
  kv_t                 pq_kvi;
  kv_t                 pq_kvo = KV_IDLE;
  logic                pq_full = 1'b0;
  logic                pq_empty = 1'b1;
  logic                pq_busy = 1'b1;

  pq_rr_sched #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_enq    (req_enq),
    .req_deq    (req_deq),
    .req_kv     (req_kv),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_kv     (rsp_kv),
    .flush      (flush),
    .flushing   (flushing),
    .flush_done (flush_done),
    .count      (count),
    .pq_enq     (pq_enq),
    .pq_deq     (pq_deq),
    .pq_kvi     (pq_kvi),
    .pq_kvo     (pq_kvo),
    .pq_full    (pq_full),
    .pq_empty   (pq_empty),
    .pq_busy    (pq_busy)
  );

  always #5 clk = ~clk;

  // Behavioural two-phase priority queue: sorted list, busy toggles every cycle.
  kv_t pq_q[$];
  always @(posedge clk) begin : pq_env
    int p;
    if (rst) begin
      pq_q.delete();
      pq_busy <= 1'b1;
    end else begin
      pq_busy <= ~pq_busy;
      if (pq_deq && pq_q.size() > 0) void'(pq_q.pop_front());
      if (pq_enq && pq_q.size() < PQ_CAPACITY) begin
        p = 0;
        while (p < pq_q.size() && pq_q[p].key <= pq_kvi.key) p++;
        pq_q.insert(p, pq_kvi);
      end
    end
    pq_full  <= (pq_q.size() == PQ_CAPACITY);
    pq_empty <= (pq_q.size() == 0);
    pq_kvo   <= (pq_q.size() > 0) ? pq_q[0] : KV_IDLE;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scheduler model state (reset values).
  logic [1:0] m_ptr = 2'd0;
  int         m_count = 0;
  bit         m_flush = 1'b0;
  bit         m_rsp_v = 1'b0;
  logic [1:0] m_rsp_i = 2'd0;
  kv_t        m_rsp_kv = KV_IDLE;

  int              gnt_log[$];
  int              gnt_cyc[$];
  int              cyc = 0;
  logic [NREQ-1:0] last_gnt = '0;
  int              last_rsp_i = -1;
  int              last_rsp_key = -1;
  int              fl_deqs = 0;
  int              fl_dones = 0;
  int              fl_bad = 0;

  always @(negedge clk) begin : compare
    logic [NREQ-1:0] e_gnt;
    logic            e_enq;
    logic            e_deq;
    logic            e_done;
    kv_t             e_kvi;
    bit              found;
    logic [1:0]      gi;
    logic [1:0]      ii;
    cyc++;
    e_gnt = '0; e_enq = 1'b0; e_deq = 1'b0; e_done = 1'b0; e_kvi = KV_IDLE;
    found = 1'b0; gi = 2'd0;
    if (!rst) begin
      if (!m_flush) begin
        if (!pq_busy) begin
          for (int k = 0; k < NREQ; k++) begin
            ii = 2'(m_ptr + 2'(k));
            if (!found && ((req_enq[ii] && !req_deq[ii] && !pq_full) ||
                           (req_deq[ii] && !pq_empty))) begin
              found = 1'b1;
              gi = ii;
            end
          end
        end
        if (found) begin
          e_gnt[gi] = 1'b1;
          e_enq = req_enq[gi];
          e_deq = req_deq[gi];
          e_kvi = req_kv[gi];
        end
      end else if (!pq_busy) begin
        if (pq_empty) e_done = 1'b1;
        else e_deq = 1'b1;
      end
    end
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("pq_enq", 32'(pq_enq), 32'(e_enq));
    check("pq_deq", 32'(pq_deq), 32'(e_deq));
    check("pq_kvi", 32'(pq_kvi), 32'(e_kvi));
    check("flush_done", 32'(flush_done), 32'(e_done));
    check("flushing", 32'(flushing), 32'(m_flush));
    check("count", 32'(count), 32'(m_count));
    check("rsp_valid", 32'(rsp_valid), m_rsp_v ? (32'd1 << m_rsp_i) : 32'd0);
    check("rsp_kv", 32'(rsp_kv), 32'(m_rsp_kv));

    for (int k = 0; k < NREQ; k++) begin
      if (gnt[k[1:0]]) begin
        gnt_log.push_back(k);
        gnt_cyc.push_back(cyc);
      end
      if (rsp_valid[k[1:0]]) begin
        last_rsp_i = k;
        last_rsp_key = int'(rsp_kv.key);
      end
    end
    if (flushing) begin
      if (pq_deq) fl_deqs++;
      if (gnt != 0 || rsp_valid != 0) fl_bad++;
    end
    if (flush_done) fl_dones++;
    last_gnt = gnt;

    if (rst) begin
      m_ptr = 2'd0; m_count = 0; m_flush = 1'b0; m_rsp_v = 1'b0; m_rsp_kv = KV_IDLE;
    end else begin
      m_rsp_v = found && req_deq[gi];
      if (m_rsp_v) begin
        m_rsp_i = gi;
        m_rsp_kv = pq_kvo;
      end
      if (e_enq && !e_deq) m_count++;
      else if (e_deq && !e_enq) m_count--;
      if (found) m_ptr = 2'(gi + 2'd1);
      if (!m_flush) begin
        if (flush) m_flush = 1'b1;
      end else if (e_done) begin
        m_flush = 1'b0;
      end
    end
  end

  // Advance one cycle; granted requests and the flush pulse are withdrawn.
  task automatic step();
    @(posedge clk);
    #1;
    req_enq = req_enq & ~last_gnt;
    req_deq = req_deq & ~last_gnt;
    flush = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while ((req_enq | req_deq) != 0 && n < bound) begin
      step();
      n++;
    end
    check(name, 32'(req_enq | req_deq), 32'd0);
  endtask

  task automatic wait_flush(input string name);
    int n = 0;
    while (flushing && n < 60) begin
      step();
      n++;
    end
    check(name, 32'(flushing), 32'd0);
  endtask

  function automatic int log_at(input int i);
    return (i < gnt_log.size()) ? gnt_log[i] : -1;
  endfunction

  function automatic kv_t mk(input int key, input int val);
    kv_t r;
    r.key = KEY_W'(key);
    r.val = VAL_W'(val);
    return r;
  endfunction

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int start;
    int n;
    int per[NREQ];

    // 1: reset
    repeat (3) step();
    check("t1_count", 32'(count), 32'd0);
    check("t1_gnt", 32'(gnt), 32'd0);
    check("t1_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t1_flushing", 32'(flushing), 32'd0);
    rst = 1'b0;

    // 2: four enqueues in one cycle, then one dequeue
    req_kv[0] = mk(40, 1); req_kv[1] = mk(10, 2); req_kv[2] = mk(30, 3); req_kv[3] = mk(20, 4);
    req_enq = 4'hF;
    wait_idle("t2_enq_timeout", 20);
    repeat (2) step();
    check("t2_ngrants", 32'(gnt_log.size()), 32'd4);
    for (int k = 0; k < 4; k++) check("t2_order", 32'(log_at(k)), 32'(k));
    for (int k = 1; k < 4; k++) check("t2_spacing", 32'(gnt_cyc[k] - gnt_cyc[k-1]), 32'd2);
    check("t2_count4", 32'(count), 32'd4);
    req_deq[1] = 1'b1;
    wait_idle("t2_deq_timeout", 10);
    repeat (2) step();
    check("t2_rsp_idx", 32'(last_rsp_i), 32'd1);
    check("t2_rsp_key", 32'(last_rsp_key), 32'd10);
    check("t2_count3", 32'(count), 32'd3);

    // 6: flush three entries
    fl_deqs = 0; fl_dones = 0; fl_bad = 0;
    flush = 1'b1;
    step();
    check("t6_flushing", 32'(flushing), 32'd1);
    wait_flush("t6_flush_timeout");
    step();
    check("t6_deqs", 32'(fl_deqs), 32'd3);
    check("t6_dones", 32'(fl_dones), 32'd1);
    check("t6_quiet", 32'(fl_bad), 32'd0);
    check("t6_count", 32'(count), 32'd0);

    // 3: dequeue on empty waits for the enqueue of another requester
    start = gnt_log.size();
    req_kv[3] = mk(7, 8'h77);
    req_deq[2] = 1'b1;
    req_enq[3] = 1'b1;
    wait_idle("t3_timeout", 12);
    repeat (2) step();
    check("t3_first", 32'(log_at(start)), 32'd3);
    check("t3_second", 32'(log_at(start + 1)), 32'd2);
    check("t3_rsp_idx", 32'(last_rsp_i), 32'd2);
    check("t3_rsp_key", 32'(last_rsp_key), 32'd7);
    check("t3_count", 32'(count), 32'd0);

    // 4: full queue blocks enqueue but not replace
    for (int f = 0; f < PQ_CAPACITY; f++) begin
      req_kv[0] = mk((f == 0) ? 3 : 20 + f, f);
      req_enq[0] = 1'b1;
      wait_idle("t4_fill_timeout", 10);
    end
    repeat (2) step();
    check("t4_count_full", 32'(count), 32'(PQ_CAPACITY));
    req_kv[0] = mk(1, 0);
    req_enq[0] = 1'b1;
    start = gnt_log.size();
    repeat (6) step();
    check("t4_no_gnt", 32'(gnt_log.size()), 32'(start));
    check("t4_pending", 32'(req_enq[0]), 32'd1);
    req_kv[1] = mk(9, 9);
    req_enq[1] = 1'b1;
    req_deq[1] = 1'b1;
    n = 0;
    while (req_deq[1] && n < 10) begin
      step();
      n++;
    end
    check("t4_rep_timeout", 32'(req_deq[1]), 32'd0);
    repeat (2) step();
    check("t4_rep_gnt", 32'(log_at(gnt_log.size() - 1)), 32'd1);
    check("t4_rsp_idx", 32'(last_rsp_i), 32'd1);
    check("t4_rsp_key", 32'(last_rsp_key), 32'd3);
    check("t4_count", 32'(count), 32'(PQ_CAPACITY));
    req_enq[0] = 1'b0;

    // 5: pointer at 2 with req1 and req3 pending, then sustained contention
    start = gnt_log.size();
    req_deq = 4'b1010;
    wait_idle("t5_timeout", 12);
    check("t5_first", 32'(log_at(start)), 32'd3);
    check("t5_second", 32'(log_at(start + 1)), 32'd1);
    repeat (2) step();
    check("t5_count", 32'(count), 32'd6);
    start = gnt_log.size();
    for (int c = 0; c < 4 * NREQ; c++) begin
      for (int k = 0; k < NREQ; k++) req_kv[k] = mk(50 + k, k);
      req_enq = 4'hF;
      req_deq = 4'hF;
      step();
    end
    req_enq = '0;
    req_deq = '0;
    repeat (2) step();
    for (int k = 0; k < NREQ; k++) per[k] = 0;
    for (int i = start; i < gnt_log.size(); i++) per[gnt_log[i]]++;
    for (int k = 0; k < NREQ; k++) check("t5_fair", 32'(per[k]), 32'd2);
    check("t5_count_rep", 32'(count), 32'd6);

    // Drain the remaining six entries
    fl_deqs = 0;
    flush = 1'b1;
    step();
    wait_flush("t7_flush_timeout");
    step();
    check("t7_deqs", 32'(fl_deqs), 32'd6);
    check("t7_count", 32'(count), 32'd0);

    // Reset in the middle of operation with a response in flight
    req_kv[0] = mk(5, 5);
    req_enq[0] = 1'b1;
    wait_idle("t8_enq_timeout", 10);
    repeat (2) step();
    req_deq[0] = 1'b1;
    wait_idle("t8_deq_timeout", 10);
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
    check("t8_count", 32'(count), 32'd0);
    check("t8_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
